// File: rtl/c64_bus_arbiter.sv
// Memory bus arbiter interleaving the 6502 (phase 1) and video fetch (phase 0),
// with ba/aec badline handshake that hands both phases to video for a burst.
module c64_bus_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 8,
  parameter int BA_LEAD = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] cpu_ab,
  input  logic [DATA_W-1:0] cpu_do,
  input  logic              cpu_we,
  output logic              cpu_rdy,
  output logic [DATA_W-1:0] cpu_di,
  output logic              cpu_di_valid,
  input  logic [ADDR_W-1:0] vic_ab,
  input  logic              vic_req,
  input  logic              vic_burst_req,
  input  logic [5:0]        vic_burst_len,
  output logic [DATA_W-1:0] vic_di,
  output logic              vic_valid,
  output logic              ba,
  output logic              aec,
  output logic              phase,
  output logic [ADDR_W-1:0] mem_ab,
  output logic [DATA_W-1:0] mem_do,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_di
);

  // state     | meaning
  // ST_NORMAL | phase 0 video reads on vic_req, phase 1 CPU access
  // ST_BA_WAIT| ba low; CPU writes still allowed, reads stalled for BA_LEAD CPU slots
  // ST_BURST  | ba/aec low; video reads in every cycle until burst_cnt runs out
  typedef enum logic [1:0] {ST_NORMAL, ST_BA_WAIT, ST_BURST} state_t;

  localparam logic [2:0] LEAD_INIT = 3'(BA_LEAD);

  state_t            state, state_nxt;
  logic              phase_q;
  logic              ba_q, ba_nxt;
  logic              aec_q, aec_nxt;
  logic [2:0]        lead_cnt, lead_nxt;
  logic [5:0]        burst_cnt, burst_nxt;
  logic [ADDR_W-1:0] last_ab;
  logic              rd_cpu_q, rd_vic_q;
  logic              vic_slot, cpu_slot;

  always_comb begin
    state_nxt = state;
    ba_nxt    = ba_q;
    aec_nxt   = aec_q;
    lead_nxt  = lead_cnt;
    burst_nxt = burst_cnt;
    vic_slot  = 1'b0;
    cpu_slot  = 1'b0;
    if (!reset) begin
      unique case (state)
        ST_NORMAL: begin
          if (!phase_q) begin
            vic_slot = vic_req;
            if (vic_burst_req && (vic_burst_len != 6'd0)) begin
              burst_nxt = vic_burst_len;
              lead_nxt  = LEAD_INIT;
              ba_nxt    = 1'b0;
              state_nxt = ST_BA_WAIT;
            end
          end else begin
            cpu_slot = 1'b1;
          end
        end
        ST_BA_WAIT: begin
          if (!phase_q) begin
            vic_slot = vic_req;
          end else begin
            cpu_slot = cpu_we;
            if (lead_cnt != 3'd0) lead_nxt = lead_cnt - 3'd1;
            if (lead_cnt <= 3'd1) begin
              aec_nxt   = 1'b0;
              state_nxt = ST_BURST;
            end
          end
        end
        ST_BURST: begin
          vic_slot = 1'b1;
          if (burst_cnt != 6'd0) burst_nxt = burst_cnt - 6'd1;
          if (burst_cnt <= 6'd1) begin
            ba_nxt    = 1'b1;
            aec_nxt   = 1'b1;
            state_nxt = ST_NORMAL;
          end
        end
        default: state_nxt = ST_NORMAL;
      endcase
    end
  end

  // Idle slots keep the previous address on the bus.
  assign cpu_rdy = cpu_slot;
  assign mem_we  = cpu_slot & cpu_we;
  assign mem_do  = mem_we ? cpu_do : '0;
  assign mem_ab  = vic_slot ? vic_ab : (cpu_slot ? cpu_ab : last_ab);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_NORMAL;
      phase_q   <= 1'b0;
      ba_q      <= 1'b1;
      aec_q     <= 1'b1;
      lead_cnt  <= 3'd0;
      burst_cnt <= 6'd0;
      last_ab   <= '0;
      rd_cpu_q  <= 1'b0;
      rd_vic_q  <= 1'b0;
    end else begin
      state     <= state_nxt;
      phase_q   <= ~phase_q;
      ba_q      <= ba_nxt;
      aec_q     <= aec_nxt;
      lead_cnt  <= lead_nxt;
      burst_cnt <= burst_nxt;
      last_ab   <= mem_ab;
      rd_cpu_q  <= cpu_slot & ~cpu_we;
      rd_vic_q  <= vic_slot;
    end
  end

  assign phase        = phase_q;
  assign ba           = ba_q;
  assign aec          = aec_q;
  assign cpu_di_valid = rd_cpu_q;
  assign vic_valid    = rd_vic_q;
  assign cpu_di       = rd_cpu_q ? mem_di : '0;
  assign vic_di       = rd_vic_q ? mem_di : '0;

endmodule

// File: tb/tb_c64_bus_arbiter.sv
// Bench for c64_bus_arbiter: directed scenarios plus random traffic against a
// slot-schedule reference model and a small memory model.
module tb_c64_bus_arbiter;
  localparam int AW   = 16;
  localparam int DW   = 8;
  localparam int LEAD = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] cpu_ab, vic_ab, mem_ab;
  logic [DW-1:0] cpu_do, cpu_di, vic_di, mem_do, mem_di;
  logic          cpu_we, cpu_rdy, cpu_di_valid, vic_req, vic_burst_req, vic_valid;
  logic [5:0]    vic_burst_len;
  logic          ba, aec, phase, mem_we;

  always #5 clk = ~clk;

  c64_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BA_LEAD(LEAD)) dut (
    .clk(clk), .reset(reset),
    .cpu_ab(cpu_ab), .cpu_do(cpu_do), .cpu_we(cpu_we), .cpu_rdy(cpu_rdy),
    .cpu_di(cpu_di), .cpu_di_valid(cpu_di_valid),
    .vic_ab(vic_ab), .vic_req(vic_req), .vic_burst_req(vic_burst_req),
    .vic_burst_len(vic_burst_len), .vic_di(vic_di), .vic_valid(vic_valid),
    .ba(ba), .aec(aec), .phase(phase),
    .mem_ab(mem_ab), .mem_do(mem_do), .mem_we(mem_we), .mem_di(mem_di)
  );

  logic [7:0] mem [0:255];
  int n_checks = 0;
  int n_fail   = 0;

  function automatic int idx(logic [15:0] a);
    return int'(a[7:0] ^ a[15:8]);
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: cycle index since reset and the burst schedule
  // (accept cycle, first burst cycle, first cycle after the burst).
  int         k, acc_cyc, b_start, b_end;
  logic [15:0] m_last_ab;
  logic       prv_cpu_rd, prv_vic_rd, prv_rdy;
  logic [7:0] prv_data;

  logic        rnd;
  logic [15:0] d_cpu_ab, d_vic_ab;
  logic [7:0]  d_cpu_do;
  logic        d_cpu_we, d_vic_req, d_burst_req;
  logic [5:0]  d_len;

  task automatic model_reset();
    k = 0; acc_cyc = -10; b_start = 0; b_end = 0;
    m_last_ab = 16'h0; prv_cpu_rd = 1'b0; prv_vic_rd = 1'b0; prv_rdy = 1'b1;
    prv_data = 8'h0;
  endtask

  task automatic drive();
    if (rnd) begin
      if (prv_rdy) begin
        cpu_ab = 16'($urandom);
        cpu_do = 8'($urandom);
        cpu_we = ($urandom_range(0, 3) == 0);
      end
      vic_ab        = 16'($urandom);
      vic_req       = 1'($urandom_range(0, 1));
      vic_burst_req = ($urandom_range(0, 7) == 0);
      vic_burst_len = 6'($urandom_range(0, 12));
    end else begin
      cpu_ab = d_cpu_ab; cpu_do = d_cpu_do; cpu_we = d_cpu_we;
      vic_ab = d_vic_ab; vic_req = d_vic_req;
      vic_burst_req = d_burst_req; vic_burst_len = d_len;
    end
  endtask

  task automatic cycle_check();
    logic ph, busy, in_burst, in_wait, ex_ba, ex_aec, vic_rd, cpu_acc, ex_we;
    logic [15:0] ex_ab;
    logic [7:0]  ex_do;
    ph       = k[0];
    busy     = (k < b_end);
    in_burst = busy && (k >= b_start);
    in_wait  = busy && (k < b_start);
    ex_ba    = !((k > acc_cyc) && (k < b_end));
    ex_aec   = !in_burst;
    vic_rd   = in_burst || (!ph && vic_req);
    cpu_acc  = !in_burst && ph && (!in_wait || cpu_we);
    ex_ab    = vic_rd ? vic_ab : (cpu_acc ? cpu_ab : m_last_ab);
    ex_we    = cpu_acc && cpu_we;
    ex_do    = ex_we ? cpu_do : 8'h0;

    check("phase", 32'(phase), 32'(ph));
    check("ba", 32'(ba), 32'(ex_ba));
    check("aec", 32'(aec), 32'(ex_aec));
    check("cpu_rdy", 32'(cpu_rdy), 32'(cpu_acc));
    check("mem_we", 32'(mem_we), 32'(ex_we));
    check("mem_ab", 32'(mem_ab), 32'(ex_ab));
    check("mem_do", 32'(mem_do), 32'(ex_do));
    check("cpu_di_valid", 32'(cpu_di_valid), 32'(prv_cpu_rd));
    check("vic_valid", 32'(vic_valid), 32'(prv_vic_rd));
    if (prv_cpu_rd) check("cpu_di", 32'(cpu_di), 32'(prv_data));
    if (prv_vic_rd) check("vic_di", 32'(vic_di), 32'(prv_data));

    if (!busy && !ph && vic_burst_req && (vic_burst_len != 6'd0)) begin
      acc_cyc = k;
      b_start = k + 2 * LEAD;
      b_end   = b_start + int'(vic_burst_len);
    end
    prv_cpu_rd = cpu_acc && !cpu_we;
    prv_vic_rd = vic_rd;
    prv_data   = mem[idx(ex_ab)];
    if (ex_we) mem[idx(cpu_ab)] = cpu_do;
    m_last_ab  = ex_ab;
    prv_rdy    = cpu_acc;
    k++;
  endtask

  task automatic run(int n);
    repeat (n) begin
      @(negedge clk);
      cycle_check();
      @(posedge clk);
      #1;
      mem_di = (prv_cpu_rd || prv_vic_rd) ? prv_data : 8'($urandom);
      drive();
    end
  endtask

  task automatic check_reset_vals(string tag);
    check({tag, "_phase"}, 32'(phase), 32'd0);
    check({tag, "_ba"}, 32'(ba), 32'd1);
    check({tag, "_aec"}, 32'(aec), 32'd1);
    check({tag, "_cpu_rdy"}, 32'(cpu_rdy), 32'd0);
    check({tag, "_cpu_di_valid"}, 32'(cpu_di_valid), 32'd0);
    check({tag, "_vic_valid"}, 32'(vic_valid), 32'd0);
    check({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    check({tag, "_mem_ab"}, 32'(mem_ab), 32'd0);
    check({tag, "_mem_do"}, 32'(mem_do), 32'd0);
    check({tag, "_cpu_di"}, 32'(cpu_di), 32'd0);
    check({tag, "_vic_di"}, 32'(vic_di), 32'd0);
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    mem_di = 8'($urandom);
    drive();
  endtask

  initial begin
    bit reached;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    reset = 1'b1;
    rnd = 1'b0;
    d_cpu_ab = 16'h1000; d_cpu_do = 8'h00; d_cpu_we = 1'b0;
    d_vic_ab = 16'h0400; d_vic_req = 1'b0; d_burst_req = 1'b0; d_len = 6'd0;
    model_reset();
    drive();
    mem_di = 8'h00;
    mem[idx(16'h1000)] = 8'h5A;
    mem[idx(16'h0400)] = 8'h20;
    #2;
    check_reset_vals("rst");
    release_reset();

    // CPU-only reads at 0x1000
    run(20);
    // Interleaved video reads at 0x0400
    d_vic_req = 1'b1;
    run(20);
    // Back-to-back bursts of 3 with the request held high throughout
    d_vic_req = 1'b0; d_burst_req = 1'b1; d_len = 6'd3;
    run(40);
    // Zero length must not start a burst
    d_len = 6'd0;
    run(20);
    // CPU writes while ba is low
    d_cpu_we = 1'b1; d_cpu_ab = 16'hD020; d_cpu_do = 8'h0E; d_len = 6'd4;
    run(30);
    d_burst_req = 1'b0;
    run(6);
    rnd = 1'b1;
    run(3000);

    // Asynchronous reset after the first of five burst reads
    rnd = 1'b0; d_cpu_we = 1'b0; d_cpu_ab = 16'h1000; d_vic_req = 1'b0;
    d_burst_req = 1'b1; d_len = 6'd5;
    reached = 1'b0;
    for (int i = 0; i < 60 && !reached; i++) begin
      run(1);
      if ((b_end > b_start) && (k == b_start + 1)) reached = 1'b1;
      else if (k > b_start + 1 && k < b_end) d_burst_req = 1'b0;
    end
    check("midburst_reached", 32'(reached), 32'd1);
    #3;
    reset = 1'b1;
    #1;
    check_reset_vals("midrst");
    d_burst_req = 1'b0;
    release_reset();
    run(12);
    rnd = 1'b1;
    run(500);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
